// File: rtl/mips_data_mem_responder_pkg.sv
// Shared constants and address-region decode for the CPU data-memory responder.
package mips_mem_pkg;

  localparam logic [31:0] MMIO_DATA_OFS   = 32'd0;
  localparam logic [31:0] MMIO_STATUS_OFS = 32'd4;

  // Status word layout: {overflow, 23'b0, fifo_count[7:0]}
  localparam int STATUS_OVF_BIT = 31;
  localparam int STATUS_CNT_LSB = 0;
  localparam int STATUS_CNT_W   = 8;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO_DATA,
    REG_MMIO_STATUS,
    REG_UNMAPPED
  } region_t;

  function automatic region_t decode_region(
    input logic [31:0] addr,
    input logic [31:0] ram_base,
    input logic [31:0] ram_bytes,
    input logic [31:0] mmio_base
  );
    logic [31:0] ram_off;
    ram_off = addr - ram_base;
    if (addr == mmio_base + MMIO_DATA_OFS) return REG_MMIO_DATA;
    if (addr == mmio_base + MMIO_STATUS_OFS) return REG_MMIO_STATUS;
    // The offset compare alone would wrap for addresses below the base.
    if (addr >= ram_base && ram_off < ram_bytes) return REG_RAM;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// CPU data-bus and output-stream signals between the CPU side and the responder.
interface mips_data_mem_responder_if;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output data_address, data_read, data_write, data_writedata, out_ready,
    input  data_readdata, out_valid, out_data
  );

  modport slave (
    input  data_address, data_read, data_write, data_writedata, out_ready,
    output data_readdata, out_valid, out_data
  );
endinterface

// File: rtl/mips_data_mem_responder_fifo.sv
// Synchronous FIFO for the MMIO output port; push is accepted when full only if a pop coincides.
module mips_mem_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty && !reset;
    push_ok  = push && (!full || pop_ok) && !reset;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder: word RAM window, two-word MMIO output port with FIFO,
// backdoor preload port and a sticky first-fault capture.
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_enable,
  mips_data_mem_responder_if.slave     bus,
  input  logic                         load_en,
  input  logic [$clog2(RAM_WORDS)-1:0] load_index,
  input  logic [31:0]                  load_data,
  output logic                         fault,
  output logic [31:0]                  fault_addr
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0] mem_q [RAM_WORDS];

  region_t          region;
  logic [IDX_W-1:0] ram_idx;
  logic             cpu_access;
  logic             bad_access;
  logic             cpu_wr;
  logic             ram_we;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_head;
  logic [31:0]      status_word;

  logic        overflow_q, overflow_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  always_comb begin
    region     = decode_region(bus.data_address, RAM_BASE, RAM_BYTES, MMIO_BASE);
    ram_idx    = IDX_W'((bus.data_address - RAM_BASE) >> 2);
    cpu_access = clk_enable && (bus.data_read || bus.data_write);
    bad_access = cpu_access && ((bus.data_address[1:0] != 2'b00) ||
                                (region == REG_UNMAPPED) ||
                                (bus.data_read && bus.data_write));
    cpu_wr     = clk_enable && bus.data_write && !bus.data_read && !bad_access;
    // A backdoor load to the same word takes priority over the CPU store.
    ram_we     = cpu_wr && (region == REG_RAM) && !(load_en && (load_index == ram_idx));
    fifo_push  = cpu_wr && (region == REG_MMIO_DATA);
    fifo_pop   = !fifo_empty && bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (ram_we)  mem_q[ram_idx]    <= bus.data_writedata;
    if (load_en) mem_q[load_index] <= load_data;
  end

  mips_mem_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (bus.data_writedata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    overflow_d   = overflow_q || (fifo_push && fifo_full && !fifo_pop);
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (bad_access && !fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = bus.data_address;
    end
    if (reset) begin
      overflow_d   = 1'b0;
      fault_d      = 1'b0;
      fault_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    overflow_q   <= overflow_d;
    fault_q      <= fault_d;
    fault_addr_q <= fault_addr_d;
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_OVF_BIT] = overflow_q;
    status_word[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(fifo_count);
  end

  always_comb begin
    bus.data_readdata = '0;
    if (bus.data_read) begin
      case (region)
        REG_RAM:         bus.data_readdata = mem_q[ram_idx];
        REG_MMIO_STATUS: bus.data_readdata = status_word;
        default:         bus.data_readdata = '0;
      endcase
    end
  end

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign fault         = fault_q;
  assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder with a queue/array reference model checked every cycle.
module tb_mips_data_mem_responder;

  localparam logic [31:0] RAM_BASE   = 32'h0000_1000;
  localparam int          RAM_WORDS  = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam int          FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_index = '0;
  logic [31:0] load_data = '0;
  logic        fault;
  logic [31:0] fault_addr;

  mips_data_mem_responder_if bus_if ();

  mips_data_mem_responder #(
    .RAM_BASE   (RAM_BASE),
    .RAM_WORDS  (RAM_WORDS),
    .MMIO_BASE  (MMIO_BASE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus_if.slave),
    .load_en    (load_en),
    .load_index (load_index),
    .load_data  (load_data),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // Reference model state
  logic [31:0] m_mem   [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [31:0] m_q [$];
  bit          m_ovf = 1'b0;
  bit          m_fault = 1'b0;
  logic [31:0] m_faddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = RAM, 1 = MMIO data, 2 = MMIO status, 3 = unmapped
  function automatic int m_region(input logic [31:0] a);
    if (a == MMIO_BASE) return 1;
    if (a == MMIO_BASE + 32'd4) return 2;
    if (longint'(a) >= longint'(RAM_BASE) &&
        longint'(a) < longint'(RAM_BASE) + 4 * RAM_WORDS) return 0;
    return 3;
  endfunction

  function automatic bit m_expect_rd(output logic [31:0] v);
    logic [31:0] a;
    int r;
    int idx;
    a = bus_if.data_address;
    r = m_region(a);
    v = '0;
    if (!bus_if.data_read) return 1'b1;
    case (r)
      0: begin
        idx = int'((a - RAM_BASE) >> 2);
        if (!m_known[idx]) return 1'b0;
        v = m_mem[idx];
      end
      2: v = {m_ovf, 23'b0, 8'(m_q.size())};
      default: v = '0;
    endcase
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    automatic logic [31:0] a  = bus_if.data_address;
    automatic logic [31:0] wd = bus_if.data_writedata;
    automatic int  r   = m_region(a);
    automatic bit  rd  = bus_if.data_read;
    automatic bit  wr  = bus_if.data_write;
    automatic bit  bad = clk_enable && (rd || wr) && (a[1:0] != 2'b00 || r == 3 || (rd && wr));
    automatic bit  ok_wr = clk_enable && wr && !rd && !bad;
    automatic bit  pop = (m_q.size() != 0) && bus_if.out_ready;
    automatic int  idx = int'((a - RAM_BASE) >> 2);
    if (ok_wr && r == 0 && !(load_en && int'(load_index) == idx)) begin
      m_mem[idx]   = wd;
      m_known[idx] = 1'b1;
    end
    if (load_en) begin
      m_mem[load_index]   = load_data;
      m_known[load_index] = 1'b1;
    end
    if (reset) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_fault = 1'b0;
      m_faddr = '0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (ok_wr && r == 1) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(wd);
        else m_ovf = 1'b1;
      end
      if (bad && !m_fault) begin
        m_fault = 1'b1;
        m_faddr = a;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (checking) begin
      chk("m_out_valid", 32'(bus_if.out_valid), 32'(m_q.size() != 0));
      chk("m_out_data", bus_if.out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
      chk("m_fault", 32'(fault), 32'(m_fault));
      chk("m_fault_addr", fault_addr, m_faddr);
      if (m_expect_rd(exp_rd)) chk("m_readdata", bus_if.data_readdata, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input bit ce, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    clk_enable            = ce;
    bus_if.data_read      = rd;
    bus_if.data_write     = wr;
    bus_if.data_address   = a;
    bus_if.data_writedata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    idle();
    bus_if.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checking = 1'b1;
    settle();
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
    chk("rst_out_data", bus_if.out_data, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);

    // Backdoor preload, then zero-latency read
    load_en = 1'b1; load_index = 10'd3; load_data = 32'hDEADBEEF;
    tick();
    load_index = 10'd0; load_data = 32'hA5A5A5A5;
    tick();
    load_en = 1'b0;
    drive(1'b1, 1'b1, 1'b0, RAM_BASE + 32'd12, 32'h0);
    settle();
    chk("load_read", bus_if.data_readdata, 32'hDEADBEEF);
    bus_if.data_read = 1'b0;
    #1 chk("read_off", bus_if.data_readdata, 32'h0);

    // CPU write with and without clk_enable
    tick();
    drive(1'b1, 1'b0, 1'b1, RAM_BASE + 32'd4, 32'h12345678);
    tick();
    drive(1'b1, 1'b1, 1'b0, RAM_BASE + 32'd4, 32'h0);
    settle();
    chk("cpu_wr_read", bus_if.data_readdata, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, 1'b1, RAM_BASE + 32'd4, 32'hCAFEF00D);
    tick();
    drive(1'b0, 1'b1, 1'b0, RAM_BASE + 32'd4, 32'h0);
    settle();
    chk("ce_low_no_wr", bus_if.data_readdata, 32'h12345678);

    // FIFO stream of three words
    tick();
    for (int v = 1; v <= 3; v++) begin
      drive(1'b1, 1'b0, 1'b1, MMIO_BASE, 32'(v));
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, MMIO_BASE + 32'd4, 32'h0);
    settle();
    chk("status_3", bus_if.data_readdata, 32'h00000003);
    idle();
    bus_if.out_ready = 1'b1;
    chk("drain_1", bus_if.out_data, 32'd1);
    tick();
    chk("drain_2", bus_if.out_data, 32'd2);
    tick();
    chk("drain_3", bus_if.out_data, 32'd3);
    tick();
    chk("drain_empty", 32'(bus_if.out_valid), 32'h0);
    bus_if.out_ready = 1'b0;

    // Fill to full, push+pop while full, then overflow
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b1, MMIO_BASE, 32'(10 + i));
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, MMIO_BASE + 32'd4, 32'h0);
    settle();
    chk("status_full", bus_if.data_readdata, 32'h00000008);
    tick();
    bus_if.out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, MMIO_BASE, 32'd99);
    tick();
    bus_if.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, MMIO_BASE + 32'd4, 32'h0);
    settle();
    chk("status_pushpop", bus_if.data_readdata, 32'h00000008);
    chk("head_after_pop", bus_if.out_data, 32'd11);
    tick();
    drive(1'b1, 1'b0, 1'b1, MMIO_BASE, 32'd18);
    tick();
    drive(1'b1, 1'b1, 1'b0, MMIO_BASE + 32'd4, 32'h0);
    settle();
    chk("status_ovf", bus_if.data_readdata, 32'h80000008);
    drive(1'b1, 1'b1, 1'b0, MMIO_BASE, 32'h0);
    #1 chk("mmio_data_read", bus_if.data_readdata, 32'h0);
    idle();
    bus_if.out_ready = 1'b1;
    repeat (7) tick();
    chk("last_kept_word", bus_if.out_data, 32'd99);
    tick();
    chk("ovf_dropped", 32'(bus_if.out_valid), 32'h0);
    bus_if.out_ready = 1'b0;

    // Faults
    drive(1'b1, 1'b0, 1'b1, RAM_BASE + 32'd2, 32'h55555555);
    tick();
    idle();
    chk("fault_set", 32'(fault), 32'h1);
    chk("fault_addr_set", fault_addr, RAM_BASE + 32'd2);
    drive(1'b1, 1'b1, 1'b0, RAM_BASE, 32'h0);
    settle();
    chk("fault_no_wr", bus_if.data_readdata, 32'hA5A5A5A5);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h00000010, 32'h0);
    tick();
    idle();
    chk("fault_addr_held", fault_addr, RAM_BASE + 32'd2);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, MMIO_BASE, 32'd77);
    tick();
    reset = 1'b0;
    idle();
    chk("fault_cleared", 32'(fault), 32'h0);
    chk("push_in_reset", 32'(bus_if.out_valid), 32'h0);

    // Backdoor/CPU collisions
    load_en = 1'b1; load_index = 10'd5; load_data = 32'h11111111;
    drive(1'b1, 1'b0, 1'b1, RAM_BASE + 32'd20, 32'h22222222);
    tick();
    load_index = 10'd6; load_data = 32'h66666666;
    drive(1'b1, 1'b0, 1'b1, RAM_BASE + 32'd28, 32'h77777777);
    tick();
    load_en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, RAM_BASE + 32'd20, 32'h0);
    settle();
    chk("collide_load_wins", bus_if.data_readdata, 32'h11111111);
    drive(1'b0, 1'b1, 1'b0, RAM_BASE + 32'd24, 32'h0);
    #1 chk("diff_load", bus_if.data_readdata, 32'h66666666);
    drive(1'b0, 1'b1, 1'b0, RAM_BASE + 32'd28, 32'h0);
    #1 chk("diff_cpu", bus_if.data_readdata, 32'h77777777);
    drive(1'b0, 1'b1, 1'b0, RAM_BASE + 32'(4 * RAM_WORDS), 32'h0);
    #1 chk("past_ram_end", bus_if.data_readdata, 32'h0);
    tick();
    idle();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
